// File: rtl/serial_word_ring_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_ring_if
//  Description : Serial bit-in / word-out bus of the serial_word_ring block.
//                The master drives serial data and control, and the slave (the
//                ring) returns the current word, word index, strobe and bit
//                position.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_word_ring_if #(
  parameter int WORD_W = 8,
  parameter int IDX_W  = 5
);
  localparam int BC_W = $clog2(WORD_W);

  logic              write;
  logic              din;
  logic              hold;
  logic              frame;
  logic [WORD_W-1:0] dout;
  logic [IDX_W-1:0]  word_idx;
  logic              word_strobe;
  logic [BC_W-1:0]   bit_cnt;

  modport master (
    output write, din, hold, frame,
    input  dout, word_idx, word_strobe, bit_cnt
  );

  modport slave (
    input  write, din, hold, frame,
    output dout, word_idx, word_strobe, bit_cnt
  );
endinterface
`default_nettype wire

// File: rtl/serial_word_ring.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_ring
//  Description : Serial-loaded circular word memory. Bits enter LSB-first into
//                working slot W[1]. On the last bit position the completed
//                word moves to W[0] (dout) and the whole ring rotates by one
//                word. Supports hold, frame resync, word index and strobe.
//                Optional macro RING_CLEAR_EN: reset also clears ring contents.
//                Without it, only the counters and the strobe are reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_ring #(
  parameter int WORD_W     = 8,
  parameter int WORD_COUNT = 20,
  parameter int IDX_W      = 5
) (
  input  wire logic         clk,
  input  wire logic         reset,
  serial_word_ring_if.slave bus
);

  localparam int                BC_W     = $clog2(WORD_W);
  localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(WORD_W - 1);
  localparam logic [BC_W-1:0]   BC_ONE   = BC_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_COUNT - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  logic [WORD_W-1:0] ring_q [WORD_COUNT];
  logic [WORD_W-1:0] ring_d [WORD_COUNT];
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              strobe_q, strobe_d;

  logic [BC_W-1:0]   w_eff_pos;
  logic              w_shift_bit;
  logic [WORD_W-1:0] w_shifted_word;
  logic              w_rotate;

  // frame restarts the word at bit 0; partial bits already in W[1] stay put
  assign w_eff_pos      = bus.frame ? '0 : bit_cnt_q;
  assign w_shift_bit    = bus.write ? bus.din : ring_q[1][0];
  assign w_shifted_word = {w_shift_bit, ring_q[1][WORD_W-1:1]};
  assign w_rotate       = (w_eff_pos == BC_LAST);

  // next state: shift into the working slot, or complete the word and rotate
  always_comb begin
    ring_d    = ring_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    strobe_d  = 1'b0;
    if (!bus.hold) begin
      if (w_rotate) begin
        ring_d[0] = w_shifted_word;
        for (int k = 1; k < WORD_COUNT - 1; k++) begin
          ring_d[k] = ring_q[k+1];
        end
        ring_d[WORD_COUNT-1] = ring_q[0];
        bit_cnt_d = '0;
        idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
        strobe_d  = 1'b1;
      end else begin
        ring_d[1] = w_shifted_word;
        bit_cnt_d = w_eff_pos + BC_ONE;
      end
    end
  end

  // counters and strobe always take the asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= '0;
      idx_q     <= '0;
      strobe_q  <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      strobe_q  <= strobe_d;
    end
  end

`ifdef RING_CLEAR_EN
  // ring storage, cleared together with the counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < WORD_COUNT; k++) begin
        ring_q[k] <= '0;
      end
    end else begin
      ring_q <= ring_d;
    end
  end
`else
  // ring storage without reset: contents are preserved while reset is held
  always_ff @(posedge clk) begin
    if (!reset) begin
      ring_q <= ring_d;
    end
  end
`endif

  assign bus.dout        = ring_q[0];
  assign bus.word_idx    = idx_q;
  assign bus.word_strobe = strobe_q;
  assign bus.bit_cnt     = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_ring.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_word_ring
//  Description : Directed bench for serial_word_ring: an 8x4 ring and a
//                16x3 ring, table vectors plus hand-written sequences for
//                hold, frame, reset and recirculation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_ring;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

`ifdef RING_CLEAR_EN
  localparam bit RING_CLEAR = 1'b1;
`else
  localparam bit RING_CLEAR = 1'b0;
`endif

  serial_word_ring_if #(.WORD_W(8),  .IDX_W(2)) bus_a ();
  serial_word_ring_if #(.WORD_W(16), .IDX_W(2)) bus_b ();

  serial_word_ring #(.WORD_W(8), .WORD_COUNT(4), .IDX_W(2)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  serial_word_ring #(.WORD_W(16), .WORD_COUNT(3), .IDX_W(2)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       w;
    logic       d;
    logic       h;
    logic       f;
    logic       ck_dout;
    logic [7:0] dout;
    logic [1:0] idx;
    logic       stb;
    logic [2:0] bc;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic a_bit(input logic w, input logic d, input logic h, input logic f);
    bus_a.write = w; bus_a.din = d; bus_a.hold = h; bus_a.frame = f;
    @(posedge clk); #1;
  endtask

  task automatic b_bit(input logic w, input logic d);
    bus_b.write = w; bus_b.din = d; bus_b.hold = 1'b0; bus_b.frame = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic a_word(input logic [7:0] v);
    for (int i = 0; i < 8; i++) a_bit(1'b1, v[i], 1'b0, 1'b0);
  endtask

  task automatic b_word(input logic [15:0] v);
    for (int i = 0; i < 16; i++) b_bit(1'b1, v[i]);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  seq_a [4];
    logic [15:0] seq_b [3];
    logic [7:0]  v;
    logic [7:0]  exp_rst_dout;

    seq_a[0] = 8'h11; seq_a[1] = 8'h22; seq_a[2] = 8'h33; seq_a[3] = 8'h44;
    seq_b[0] = 16'hBEEF; seq_b[1] = 16'h1234; seq_b[2] = 16'h0F0F;

    // 0xA5 LSB-first = 1,0,1,0,0,1,0,1 ; last row is a hold cycle after rotation
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'd1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'd2};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'd3};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'd4};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'd5};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'd6};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'd7};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd1, 1'b1, 3'd0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 2'd1, 1'b0, 3'd0};

    bus_a.write = 1'b0; bus_a.din = 1'b0; bus_a.hold = 1'b1; bus_a.frame = 1'b0;
    bus_b.write = 1'b0; bus_b.din = 1'b0; bus_b.hold = 1'b1; bus_b.frame = 1'b0;

    // power-up reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bc", bus_a.bit_cnt, 0);
    chk("rst_idx", bus_a.word_idx, 0);
    chk("rst_stb", bus_a.word_strobe, 0);
    reset = 1'b0;

    // test 1: single word 0xA5
    for (int i = 0; i < 9; i++) begin
      a_bit(tbl[i].w, tbl[i].d, tbl[i].h, tbl[i].f);
      chk($sformatf("t1_bc[%0d]", i), bus_a.bit_cnt, tbl[i].bc);
      chk($sformatf("t1_idx[%0d]", i), bus_a.word_idx, tbl[i].idx);
      chk($sformatf("t1_stb[%0d]", i), bus_a.word_strobe, tbl[i].stb);
      if (tbl[i].ck_dout) chk($sformatf("t1_dout[%0d]", i), bus_a.dout, tbl[i].dout);
    end

    // test 2: fill all four words, then recirculate for 8 rotations
    pulse_reset();
    for (int w = 0; w < 4; w++) begin
      a_word(seq_a[w]);
      chk($sformatf("t2_wr_dout[%0d]", w), bus_a.dout, seq_a[w]);
      chk($sformatf("t2_wr_idx[%0d]", w), bus_a.word_idx, (w + 1) % 4);
    end
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < 8; b++) begin
        a_bit(1'b0, 1'b1, 1'b0, 1'b0);
        if (b == 3) chk($sformatf("t2_stable[%0d]", r), bus_a.dout, seq_a[(r + 3) % 4]);
      end
      chk($sformatf("t2_dout[%0d]", r), bus_a.dout, seq_a[r % 4]);
      chk($sformatf("t2_idx[%0d]", r), bus_a.word_idx, (r + 1) % 4);
      chk($sformatf("t2_stb[%0d]", r), bus_a.word_strobe, 1);
    end

    // test 3: hold for 5 cycles at bit_cnt=3 while writing 0x3C
    v = 8'h3C;
    for (int i = 0; i < 3; i++) a_bit(1'b1, v[i], 1'b0, 1'b0);
    chk("t3_pre_bc", bus_a.bit_cnt, 3);
    for (int i = 0; i < 5; i++) begin
      a_bit(1'b1, i[0], 1'b1, (i == 2));
      chk($sformatf("t3_hold_bc[%0d]", i), bus_a.bit_cnt, 3);
      chk($sformatf("t3_hold_dout[%0d]", i), bus_a.dout, 8'h44);
      chk($sformatf("t3_hold_idx[%0d]", i), bus_a.word_idx, 0);
      chk($sformatf("t3_hold_stb[%0d]", i), bus_a.word_strobe, 0);
    end
    for (int i = 3; i < 8; i++) a_bit(1'b1, v[i], 1'b0, 1'b0);
    chk("t3_dout", bus_a.dout, 8'h3C);
    chk("t3_stb", bus_a.word_strobe, 1);
    chk("t3_idx", bus_a.word_idx, 1);

    // test 4: frame at bit_cnt=5, and a frame ignored under hold
    v = 8'h5A;
    for (int i = 0; i < 5; i++) a_bit(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_pre_bc", bus_a.bit_cnt, 5);
    a_bit(1'b1, v[0], 1'b0, 1'b1);
    chk("t4_frame_bc", bus_a.bit_cnt, 1);
    chk("t4_frame_stb", bus_a.word_strobe, 0);
    a_bit(1'b1, v[1], 1'b0, 1'b0);
    a_bit(1'b1, v[2], 1'b0, 1'b0);
    a_bit(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t4_holdframe_bc", bus_a.bit_cnt, 3);
    for (int i = 3; i < 7; i++) a_bit(1'b1, v[i], 1'b0, 1'b0);
    chk("t4_pre_rot_bc", bus_a.bit_cnt, 7);
    chk("t4_pre_rot_stb", bus_a.word_strobe, 0);
    chk("t4_pre_rot_dout", bus_a.dout, 8'h3C);
    a_bit(1'b1, v[7], 1'b0, 1'b0);
    chk("t4_dout", bus_a.dout, 8'h5A);
    chk("t4_stb", bus_a.word_strobe, 1);
    chk("t4_idx", bus_a.word_idx, 2);
    chk("t4_bc", bus_a.bit_cnt, 0);

    // test 5a: asynchronous reset clears a live strobe immediately
    a_word(8'h81);
    chk("t5_stb_before", bus_a.word_strobe, 1);
    reset = 1'b1;
    #2;
    chk("t5_async_stb", bus_a.word_strobe, 0);
    chk("t5_async_idx", bus_a.word_idx, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // test 5b: reset mid-word after two words
    a_word(8'h81);
    a_word(8'h7E);
    chk("t5_dout_pre", bus_a.dout, 8'h7E);
    chk("t5_idx_pre", bus_a.word_idx, 2);
    for (int i = 0; i < 4; i++) a_bit(1'b1, i[0], 1'b0, 1'b0);
    chk("t5_bc_pre", bus_a.bit_cnt, 4);
    exp_rst_dout = RING_CLEAR ? 8'h00 : 8'h7E;
    reset = 1'b1;
    #2;
    chk("t5_rst_bc", bus_a.bit_cnt, 0);
    chk("t5_rst_idx", bus_a.word_idx, 0);
    chk("t5_rst_stb", bus_a.word_strobe, 0);
    chk("t5_rst_dout", bus_a.dout, exp_rst_dout);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_rst_hold_dout", bus_a.dout, exp_rst_dout);
    chk("t5_rst_hold_bc", bus_a.bit_cnt, 0);
    reset = 1'b0;
    bus_a.hold = 1'b1;

    // test 6: 16-bit words in a 3-word ring
    for (int w = 0; w < 3; w++) begin
      b_word(seq_b[w]);
      chk($sformatf("t6_wr_dout[%0d]", w), bus_b.dout, seq_b[w]);
    end
    chk("t6_wr_idx", bus_b.word_idx, 0);
    for (int r = 0; r < 6; r++) begin
      for (int b = 0; b < 16; b++) begin
        b_bit(1'b0, 1'b0);
        if (b == 8) begin
          chk($sformatf("t6_stable[%0d]", r), bus_b.dout, seq_b[(r + 2) % 3]);
          chk($sformatf("t6_mid_stb[%0d]", r), bus_b.word_strobe, 0);
        end
      end
      chk($sformatf("t6_dout[%0d]", r), bus_b.dout, seq_b[r % 3]);
      chk($sformatf("t6_idx[%0d]", r), bus_b.word_idx, (r + 1) % 3);
      chk($sformatf("t6_stb[%0d]", r), bus_b.word_strobe, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_word_ring.md
Name: serial_word_ring

Overview:
Parametrised serial-loaded circular word memory. Bits arrive one per enabled clock, LSB-first, into a working slot; every WORD_W bits the whole ring rotates by one word and the completed word is presented on dout. The block adds hold, frame resync, a word index and a word strobe, and serves as the scratch/pattern memory behind the 8-bit pin-limited top level.

Parameters:
WORD_W, 8, bits per word (>= 2)
WORD_COUNT, 20, words in ring (>= 3)
IDX_W, 5, width of word_idx; must equal ceil(log2(WORD_COUNT))

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
write  input  1  1: shift din into the working slot; 0: recirculate the slot's own LSB
din  input  1  serial data bit
hold  input  1  1: freeze all state this cycle
frame  input  1  sync: the current cycle is bit 0 of a new word
dout  output  WORD_W  word slot W[0], the last completed word
word_idx  output  IDX_W  rotation count mod WORD_COUNT
word_strobe  output  1  one-cycle pulse after each rotation
bit_cnt  output  ceil(log2(WORD_W))  bit position of the next enabled cycle

Behaviour:
- Storage is words W[0..WORD_COUNT-1]; dout = W[0]; W[1] is the working slot.
- Enabled cycle: hold=0 and reset=0. When hold=1, nothing changes, word_strobe is forced to 0, and frame is ignored.
- Effective bit position e = 0 if frame=1, else bit_cnt.
- Shift bit b = write ? din : W[1][0].
- If e < WORD_W-1:
  - W[1] <= {b, W[1][WORD_W-1:1]}.
  - bit_cnt <= e+1.
  - word_strobe <= 0.
- If e = WORD_W-1 (rotation):
  - W[0] <= {b, W[1][WORD_W-1:1]}.
  - W[k] <= W[k+1] for k = 1..WORD_COUNT-2.
  - W[WORD_COUNT-1] <= old W[0].
  - bit_cnt <= 0.
  - word_idx <= (word_idx = WORD_COUNT-1) ? 0 : word_idx+1.
  - word_strobe <= 1.
- Ring period is WORD_COUNT rotations (WORD_COUNT*WORD_W enabled cycles). A word reappears on dout every WORD_COUNT rotations.
- dout changes only on rotation edges and is stable for at least WORD_W enabled cycles.
- Frame mid-word: partial bits already shifted into W[1] stay in place (no restore). Rotation occurs WORD_W-1 enabled cycles after the frame cycle.
- frame while bit_cnt=0: no effect beyond normal operation.
- write may toggle per bit. A word can mix new and recirculated bits.
- Latency: bit presented at edge n of the last bit position is visible on dout after that edge. word_strobe is high during the following cycle.
- Reset (async, any time, including mid-word or mid-hold):
  - bit_cnt = 0, word_idx = 0, word_strobe = 0.
  - Ring contents handled per the optional feature.
  - Deassertion is synchronous to clk in the parent design.

Optional Feature:
Macro RING_CLEAR_EN.
- Defined: reset also clears all W[k] to 0, so dout = 0 during and after reset.
- Not defined: ring contents have no reset, are preserved across reset, and are unspecified after power-up. Only counters and strobe reset. This saves area on large rings.

Test Plan:
1. WORD_W=8, WORD_COUNT=4, RING_CLEAR_EN: reset, write=1, din = 0xA5 LSB-first over 8 cycles -> dout=0xA5 after 8th edge, word_idx=1, word_strobe high exactly 1 cycle, bit_cnt=0.
2. Write 0x11, 0x22, 0x33, 0x44 (32 cycles), then write=0 for 64 cycles -> dout sequence 0x11, 0x22, 0x33, 0x44, 0x11, ... one word per 8 cycles; word_idx 1, 2, 3, 0 wraps.
3. Assert hold for 5 cycles at bit_cnt=3 with din toggling -> bit_cnt, dout, word_idx unchanged during hold, no strobe; word 0x3C completes after 8 enabled cycles total.
4. frame pulse at bit_cnt=5 -> bit_cnt=1 next edge; rotation 7 enabled cycles later; frame together with hold=1 -> ignored.
5. Reset asserted at bit_cnt=4 after 2 words written -> bit_cnt=0, word_idx=0, word_strobe=0 immediately. dout=0 with RING_CLEAR_EN; dout retains its prior value without the macro.
6. WORD_W=16, WORD_COUNT=3: write 0xBEEF, 0x1234, 0x0F0F, then recirculate -> dout cycles 0xBEEF, 0x1234, 0x0F0F every 16 cycles; word_idx wraps 2 -> 0.
